// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg: field offsets of the exec/writeback buffers and the stage states.
// ---------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

    // Exec-buffer offsets; control fields sit above bit N, opCode/opType above bit 2N.
    localparam int EX_RC       = 0;
    localparam int EX_REGWRITE = 4;
    localparam int EX_MEMTOREG = 5;
    localparam int EX_MEMWRITE = 6;
    localparam int EX_BRANCH   = 7;
    localparam int EX_NEG      = 8;
    localparam int EX_ZERO     = 9;
    localparam int EX_ALU      = 10;
    localparam int EX_OPCODE   = 10;
    localparam int EX_OPTYPE   = 14;
    localparam int RC_W        = 4;

    // Writeback-buffer offsets above bit 2N.
    localparam int WB_RC       = 0;
    localparam int WB_REGWRITE = 4;
    localparam int WB_MEMTOREG = 5;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_wait_counter.sv
// ---------------------------------------------------------------------------
// mem_wait_counter: saturating access-wait counter, terminal count at TIMEOUT-1.
// ---------------------------------------------------------------------------
`default_nettype none

module mem_wait_counter #(
    parameter int TIMEOUT = 15,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CW'(TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage: memory pipeline stage with req/ack data-memory access and timeout.
// ---------------------------------------------------------------------------
`default_nettype none

module mem_stage
    import mem_pkg::*;
#(
    parameter int N       = 24,
    parameter int BW      = 64,
    parameter int WBW     = 54,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [BW-1:0]  execBuffer,
    output logic           memReq,
    output logic           memWe,
    output logic [N-1:0]   memAddr,
    output logic [N-1:0]   memWData,
    input  logic [N-1:0]   memRData,
    input  logic           memAck,
    output logic           stall,
    output logic [WBW-1:0] wbBuffer,
    output logic           branchTaken,
    output logic [N-1:0]   pcTarget,
    output logic           memFault
);

    mem_state_e state, state_nxt;

    logic [N-1:0]    ex_alu, ex_rd3;
    logic [RC_W-1:0] ex_rc;
    logic            ex_rw, ex_m2r, ex_mw, ex_br, ex_z, ex_memop;

    assign ex_rd3   = execBuffer[0 +: N];
    assign ex_rc    = execBuffer[N+EX_RC +: RC_W];
    assign ex_rw    = execBuffer[N+EX_REGWRITE];
    assign ex_m2r   = execBuffer[N+EX_MEMTOREG];
    assign ex_mw    = execBuffer[N+EX_MEMWRITE];
    assign ex_br    = execBuffer[N+EX_BRANCH];
    assign ex_z     = execBuffer[N+EX_ZERO];
    assign ex_alu   = execBuffer[N+EX_ALU +: N];
    assign ex_memop = ex_mw | ex_m2r;

    logic unused_fields;
    assign unused_fields = ^{execBuffer[N+EX_NEG], execBuffer[2*N+EX_OPTYPE+1 : 2*N+EX_OPCODE]};

    // Holding register of the instruction in flight; alu/rd3 double as memAddr/memWData.
    logic [N-1:0]    h_alu, h_rd3;
    logic [RC_W-1:0] h_rc;
    logic            h_rw, h_m2r, h_mw, h_br, h_z;

    logic in_access, capture, retire_alu, retire_ack, retire_tmo, tc;

    assign in_access  = (state == ACCESS);
    assign capture    = (state == IDLE) && en && ex_memop;
    assign retire_alu = (state == IDLE) && en && !ex_memop;
    assign retire_ack = in_access && memAck;
    assign retire_tmo = in_access && !memAck && tc;

    mem_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait (
        .clk (clk),
        .rst (rst),
        .clr (capture),
        .inc (in_access),
        .tc  (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (capture) begin
            state_nxt = ACCESS;
        end else if (retire_ack || retire_tmo) begin
            state_nxt = IDLE;
        end
    end

    function automatic logic [WBW-1:0] pack_wb(
        input logic [N-1:0]    alu,
        input logic [N-1:0]    rdata,
        input logic [RC_W-1:0] rc,
        input logic            rw,
        input logic            m2r
    );
        logic [WBW-1:0] p;
        p                      = '0;
        p[0 +: N]              = alu;
        p[N +: N]              = rdata;
        p[2*N+WB_RC +: RC_W]   = rc;
        p[2*N+WB_REGWRITE]     = rw;
        p[2*N+WB_MEMTOREG]     = m2r;
        return p;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_alu       <= '0;
            h_rd3       <= '0;
            h_rc        <= '0;
            h_rw        <= 1'b0;
            h_m2r       <= 1'b0;
            h_mw        <= 1'b0;
            h_br        <= 1'b0;
            h_z         <= 1'b0;
            wbBuffer    <= '0;
            branchTaken <= 1'b0;
            pcTarget    <= '0;
            memFault    <= 1'b0;
        end else begin
            branchTaken <= 1'b0;
            if (capture) begin
                h_alu <= ex_alu;
                h_rd3 <= ex_rd3;
                h_rc  <= ex_rc;
                h_rw  <= ex_rw;
                h_m2r <= ex_m2r;
                h_mw  <= ex_mw;
                h_br  <= ex_br;
                h_z   <= ex_z;
            end
            if (retire_alu) begin
                wbBuffer    <= pack_wb(ex_alu, '0, ex_rc, ex_rw, 1'b0);
                branchTaken <= ex_br & ex_z;
                pcTarget    <= ex_alu;
            end else if (retire_ack || retire_tmo) begin
                // A store (including memWrite+memToReg) never returns read data.
                wbBuffer    <= pack_wb(h_alu, (retire_ack && !h_mw) ? memRData : '0,
                                       h_rc, h_rw & retire_ack, h_m2r & ~h_mw);
                branchTaken <= h_br & h_z;
                pcTarget    <= h_alu;
                if (retire_tmo) begin
                    memFault <= 1'b1;
                end
            end
        end
    end

    assign memReq   = in_access;
    assign memWe    = in_access & h_mw;
    assign memAddr  = h_alu;
    assign memWData = h_rd3;
    assign stall    = in_access;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage: directed + randomized bench for mem_stage against a transaction model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

    localparam int N       = 24;
    localparam int BW      = 64;
    localparam int WBW     = 54;
    localparam int TIMEOUT = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [BW-1:0]  execBuffer;
    logic           memReq, memWe, memAck, stall, branchTaken, memFault;
    logic [N-1:0]   memAddr, memWData, memRData, pcTarget;
    logic [WBW-1:0] wbBuffer;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_stage #(.N(N), .BW(BW), .WBW(WBW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .en(en), .execBuffer(execBuffer),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memRData(memRData), .memAck(memAck), .stall(stall), .wbBuffer(wbBuffer),
        .branchTaken(branchTaken), .pcTarget(pcTarget), .memFault(memFault)
    );

    typedef struct {
        logic [N-1:0] alu;
        logic [N-1:0] rd3;
        logic [3:0]   rc;
        logic         rw, m2r, mw, br, z;
    } instr_t;

    // Reference model: one optional instruction in flight plus its elapsed ACCESS cycles.
    instr_t         cur, held;
    bit             m_busy;
    int             m_wait;
    logic [WBW-1:0] m_wb;
    logic           m_bt, m_fault;
    logic [N-1:0]   m_pc, m_addr, m_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] pack_ex(input instr_t i);
        logic [1:0] opt;
        logic [3:0] opc;
        logic       neg;
        opt = 2'($urandom);
        opc = 4'($urandom);
        neg = 1'($urandom);
        return {opt, opc, i.alu, i.z, neg, i.br, i.mw, i.m2r, i.rw, i.rc, i.rd3};
    endfunction

    function automatic logic [WBW-1:0] wb_of(input logic m2r, input logic rw, input logic [3:0] rc,
                                             input logic [N-1:0] rdata, input logic [N-1:0] alu);
        return {m2r, rw, rc, rdata, alu};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_wait = 0; m_wb = '0; m_bt = 0; m_fault = 0;
        m_pc = '0; m_addr = '0; m_wdata = '0;
    endtask

    task automatic model_edge();
        logic bt_next;
        bt_next = 1'b0;
        if (!m_busy) begin
            if (en) begin
                if (cur.mw || cur.m2r) begin
                    held = cur; m_busy = 1; m_wait = 0;
                    m_addr = cur.alu; m_wdata = cur.rd3;
                end else begin
                    m_wb = wb_of(1'b0, cur.rw, cur.rc, '0, cur.alu);
                    bt_next = cur.br & cur.z;
                    m_pc = cur.alu;
                end
            end
        end else begin
            m_wait++;
            if (memAck) begin
                m_wb = wb_of(held.m2r && !held.mw, held.rw, held.rc,
                             held.mw ? '0 : memRData, held.alu);
                bt_next = held.br & held.z; m_pc = held.alu; m_busy = 0;
            end else if (m_wait == TIMEOUT) begin
                m_wb = wb_of(held.m2r && !held.mw, 1'b0, held.rc, '0, held.alu);
                bt_next = held.br & held.z; m_pc = held.alu; m_busy = 0;
                m_fault = 1;
            end
        end
        m_bt = bt_next;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".wb"},      64'(wbBuffer),    64'(m_wb));
        check({tag, ".req"},     64'(memReq),      64'(m_busy));
        check({tag, ".we"},      64'(memWe),       64'(m_busy && held.mw));
        check({tag, ".addr"},    64'(memAddr),     64'(m_addr));
        check({tag, ".wdata"},   64'(memWData),    64'(m_wdata));
        check({tag, ".stall"},   64'(stall),       64'(m_busy));
        check({tag, ".bt"},      64'(branchTaken), 64'(m_bt));
        check({tag, ".pc"},      64'(pcTarget),    64'(m_pc));
        check({tag, ".fault"},   64'(memFault),    64'(m_fault));
    endtask

    task automatic step(input string tag, input logic e, input instr_t i,
                        input logic ack, input logic [N-1:0] rdata);
        @(negedge clk);
        en = e; cur = i; execBuffer = pack_ex(i); memAck = ack; memRData = rdata;
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    function automatic instr_t mk(input logic [N-1:0] alu, input logic [N-1:0] rd3, input logic [3:0] rc,
                                  input logic rw, input logic m2r, input logic mw,
                                  input logic br, input logic z);
        instr_t t;
        t.alu = alu; t.rd3 = rd3; t.rc = rc; t.rw = rw; t.m2r = m2r; t.mw = mw; t.br = br; t.z = z;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int k;
        k = $urandom_range(0, 7);
        t = mk(N'($urandom), N'($urandom), 4'($urandom), 1'($urandom),
               k inside {4, 5, 7}, k inside {6, 7}, 1'($urandom), 1'($urandom));
        return t;
    endfunction

    instr_t nop;
    int stall_cycles;

    initial begin
        nop = mk('0, '0, '0, 0, 0, 0, 0, 0);
        rst = 1'b0; en = 1'b0; execBuffer = '0; memAck = 1'b0; memRData = '0; cur = nop; held = nop;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // ALU op
        step("alu", 1, mk(4, 0, 3, 1, 0, 0, 0, 0), 0, 0);
        check("alu.res", 64'(wbBuffer[23:0]), 64'd4);
        check("alu.rc",  64'(wbBuffer[51:48]), 64'd3);
        check("alu.rw",  64'(wbBuffer[52]), 64'd1);

        // Load, acked on 3rd ACCESS cycle
        step("ld.cap", 1, mk(10, 0, 5, 1, 1, 0, 0, 0), 0, 0);
        check("ld.addr", 64'(memAddr), 64'd10);
        check("ld.we",   64'(memWe), 64'd0);
        stall_cycles = 0;
        for (int c = 0; c < 3; c++) begin
            if (stall) stall_cycles++;
            step("ld.acc", 1, nop, c == 2, (c == 2) ? 24'h00ABCD : 24'h0);
        end
        check("ld.stallcnt", 64'(stall_cycles), 64'd3);
        check("ld.rdata", 64'(wbBuffer[47:24]), 64'h00ABCD);
        check("ld.m2r",   64'(wbBuffer[53]), 64'd1);

        // Store with immediate ack
        step("st.cap", 1, mk(5, 24'hFFFFFF, 2, 0, 0, 1, 0, 0), 0, 0);
        check("st.we",    64'(memWe), 64'd1);
        check("st.wdata", 64'(memWData), 64'hFFFFFF);
        step("st.ack", 1, nop, 1, 24'h123456);
        check("st.stall", 64'(stall), 64'd0);
        check("st.rdata", 64'(wbBuffer[47:24]), 64'd0);

        // Branch taken / not taken
        step("br.t", 1, mk(7, 0, 0, 0, 0, 0, 1, 1), 0, 0);
        check("br.t.bt", 64'(branchTaken), 64'd1);
        check("br.t.pc", 64'(pcTarget), 64'd7);
        step("br.hold", 0, nop, 0, 0);
        check("br.pulse", 64'(branchTaken), 64'd0);
        step("br.nt", 1, mk(9, 0, 0, 0, 0, 0, 1, 0), 0, 0);
        check("br.nt.bt", 64'(branchTaken), 64'd0);

        // Load timeout
        step("to.cap", 1, mk(33, 0, 6, 1, 1, 0, 0, 0), 0, 0);
        for (int c = 0; c < TIMEOUT; c++) begin
            step("to.acc", 1, nop, 0, 0);
            if (c == TIMEOUT - 2) check("to.early", 64'(memFault), 64'd0);
        end
        check("to.fault", 64'(memFault), 64'd1);
        check("to.rw",    64'(wbBuffer[52]), 64'd0);
        check("to.idle",  64'(stall), 64'd0);
        step("to.after", 1, mk(1, 0, 1, 1, 0, 0, 0, 0), 0, 0);
        check("to.sticky", 64'(memFault), 64'd1);

        // Reset mid-ACCESS, then a late ack
        step("rs.cap", 1, mk(44, 55, 7, 1, 1, 0, 1, 1), 0, 0);
        step("rs.acc", 1, nop, 0, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        held = nop;
        #1;
        compare_all("rs.async");
        @(negedge clk);
        rst = 1'b1;
        step("rs.lateack", 0, nop, 1, 24'hBEEF);
        step("rs.alu", 1, mk(12, 0, 4, 1, 0, 0, 0, 0), 0, 0);
        check("rs.alu.res", 64'(wbBuffer[23:0]), 64'd12);

        // Randomized traffic; second half makes acks rare to exercise timeouts
        for (int n = 0; n < 1200; n++) begin
            int ack_odds;
            ack_odds = (n < 600) ? 3 : 24;
            step("rnd", $urandom_range(0, 7) != 0, rand_instr(),
                 $urandom_range(0, ack_odds) == 0, N'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory pipeline stage; the consumer of the execute-stage buffer. Unpacks the exec buffer (ALU result, store data, destination register, control bits, flags) and runs a req/ack transaction with data memory for loads and stores. Stalls upstream while the access is pending, then writes the memory/writeback buffer for the writeback stage and reports branch resolution.

## Interface
Parameters:
- N, 24: register/data width
- BW, 64: exec buffer width (16 control/flag bits + 2·N)
- WBW, 54: writeback buffer width (2·N + 6)
- TIMEOUT, 15: maximum ACCESS cycles without memAck before fault

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  pipeline enable from hazard unit; sampled only in IDLE
- execBuffer  in  BW  [N-1:0] rd3 (store data), [N+3:N] Rc, [N+4] regWrite, [N+5] memToReg, [N+6] memWrite, [N+7] branchFlag, [N+8] negFlag, [N+9] zeroFlag, [2N+9:N+10] aluResult, [2N+13:2N+10] opCode, [2N+15:2N+14] opType
- memReq  out  1  access request, high throughout ACCESS
- memWe  out  1  1 = store, 0 = load; valid while memReq
- memAddr  out  N  held aluResult
- memWData  out  N  held rd3
- memRData  in  N  load data, sampled with memAck
- memAck  in  1  access complete; ignored outside ACCESS
- stall  out  1  freeze exec stage; equals (state == ACCESS)
- wbBuffer  out  WBW  [N-1:0] aluResult, [2N-1:N] readData, [2N+3:2N] Rc, [2N+4] regWrite, [2N+5] memToReg
- branchTaken  out  1  branchFlag & zeroFlag of last retired instruction
- pcTarget  out  N  aluResult of last retired instruction
- memFault  out  1  sticky timeout flag

## Operation
- States: IDLE, ACCESS.
- IDLE, en=1, no memory op: at the edge, wbBuffer loads aluResult, readData=0, Rc, regWrite, memToReg=0; branchTaken/pcTarget update. State stays IDLE.
- IDLE, en=1, memWrite or memToReg set: capture all fields into holding register; go to ACCESS; waitCnt cleared.
- memWrite and memToReg both set: treated as store; memToReg and readData forced 0 in wbBuffer.
- IDLE, en=0: all registers hold; branchTaken cleared to 0 (one-cycle pulse semantics).
- ACCESS: memReq=1, memWe=held memWrite, memAddr/memWData from holding register; execBuffer and en ignored; waitCnt increments each cycle.
- ACCESS, memAck=1: wbBuffer loads held fields plus readData=memRData (load) or 0 (store); branchTaken/pcTarget update; go to IDLE.
- ACCESS, waitCnt reaches TIMEOUT-1 without memAck: memFault set; wbBuffer loads held fields with regWrite=0, readData=0; go to IDLE. memFault clears only on reset.
- branchTaken is high for exactly the cycle after the retiring edge, then 0 until the next retirement.
- Outputs outside ACCESS: memReq=0, memWe=0, memAddr/memWData hold last values.
- Reset (any time, including mid-ACCESS): state IDLE, wbBuffer 0, memReq 0, memWe 0, memAddr 0, memWData 0, stall 0, branchTaken 0, pcTarget 0, memFault 0, waitCnt 0. An access in flight is dropped; a late memAck is ignored.

## Timing
- Non-memory op: captured at edge E0; wbBuffer valid after E0 (latency 1, no stall).
- Memory op: captured at E0; memReq and stall high from E0 until the edge that samples memAck=1. Ack on the first ACCESS cycle: wbBuffer valid after E1, stall high for 1 cycle.
- An ack sampled at Ek gives stall low after Ek; the instruction held by exec is captured at Ek+1.
- Timeout: fault retirement occurs at the TIMEOUT-th ACCESS edge.
- Arithmetic: waitCnt width $clog2(TIMEOUT+1), no wrap; all data paths are pass-through, no sign handling.

## Structure
- Package mem_pkg: exec-buffer and wbBuffer field offset localparams, state enum typedef (IDLE, ACCESS).
- One sub-module, mem_wait_counter: clear/enable counter with terminal-count output at TIMEOUT-1.

## Test plan
- ALU op (aluResult=4, Rc=3, regWrite=1) -> wbBuffer[23:0]=4, Rc=3, regWrite=1, readData=0 after one edge; stall never high.
- Load (memToReg=1, aluResult=10), memAck with memRData=0x00ABCD on 3rd ACCESS cycle -> memAddr=10, memWe=0, stall high 3 cycles, wbBuffer readData=0x00ABCD, memToReg=1.
- Store (memWrite=1, aluResult=5, rd3=-1) with immediate ack -> memWe=1, memWData=0xFFFFFF, 1 stall cycle, wbBuffer regWrite=0, readData=0.
- Branch op (branchFlag=1, zeroFlag=1, aluResult=7) -> branchTaken=1 for one cycle, pcTarget=7; same with zeroFlag=0 -> branchTaken=0.
- Load with no ack -> memFault=1 after 15 ACCESS cycles, wbBuffer regWrite=0, state IDLE; memFault stays 1 across later ops.
- rst low mid-ACCESS, then memAck pulse after release -> all outputs 0, ack ignored, next ALU op retires normally.
